// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package bcd_timer_pkg;

  localparam int unsigned BCD_W             = 4;
  localparam int unsigned DIGIT_MAX_DEFAULT = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One decade of the countdown chain: loads a saturated preset, decrements on
// an incoming borrow and wraps to DIGIT_MAX when borrowing from zero.
module bcd_down_digit
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGIT_MAX = DIGIT_MAX_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_val,
  input  logic             i_borrow_in,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_borrow_out,
  output logic             o_is_zero
);

  localparam logic [BCD_W-1:0] DMAX = BCD_W'(DIGIT_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_digit <= '0;
    end else if (i_load) begin
      o_digit <= (i_load_val > DMAX) ? DMAX : i_load_val;
    end else if (i_borrow_in) begin
      o_digit <= (o_digit == '0) ? DMAX : o_digit - 1'b1;
    end
  end

  assign o_is_zero    = (o_digit == '0);
  assign o_borrow_out = i_borrow_in & o_is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with load/start/pause control and a
// registered one-cycle expiry pulse.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIGIT_MAX  = DIGIT_MAX_DEFAULT
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_tick,
  input  logic                        i_load,
  input  logic [BCD_W*NUM_DIGITS-1:0] i_load_value,
  input  logic                        i_start,
  input  logic                        i_pause,
  output logic [BCD_W*NUM_DIGITS-1:0] o_digits,
  output logic                        o_running,
  output logic                        o_zero,
  output logic                        o_done
);

  timer_state_t state, state_next;
  logic                  done_next;
  logic                  dec_en;
  logic                  last_step;
  logic [NUM_DIGITS:0]   borrow;
  logic [NUM_DIGITS-1:0] is_zero;

  assign dec_en    = (state == RUN) & i_tick & ~i_pause;
  assign borrow[0] = dec_en;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_down_digit #(
      .DIGIT_MAX(DIGIT_MAX)
    ) u_digit (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_load      (i_load),
      .i_load_val  (i_load_value[g*BCD_W +: BCD_W]),
      .i_borrow_in (borrow[g]),
      .o_digit     (o_digits[g*BCD_W +: BCD_W]),
      .o_borrow_out(borrow[g+1]),
      .o_is_zero   (is_zero[g])
    );
  end

  assign o_zero = &is_zero;

  // Value is exactly 1, so this decrement lands on zero. A borrow escaping
  // the top digit is unreachable from legal states; it is folded in as expiry.
  assign last_step = ((o_digits[BCD_W-1:0] == BCD_W'(1)) &&
                      (&(is_zero | NUM_DIGITS'(1)))) || borrow[NUM_DIGITS];

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (i_load) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            if (o_zero) begin
              state_next = EXPIRED;
              done_next  = 1'b1;
            end else begin
              state_next = RUN;
            end
          end
        end
        RUN: begin
          if (i_pause) begin
            state_next = PAUSED;
          end else if (dec_en && last_step) begin
            state_next = EXPIRED;
            done_next  = 1'b1;
          end
        end
        PAUSED: begin
          if (i_start && !i_pause) state_next = RUN;
        end
        EXPIRED: state_next = EXPIRED;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_running <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_next;
      o_running <= (state_next == RUN);
      o_done    <= done_next;
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: vector table, directed sequences and
// random stimulus against an integer-valued reference model.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst, tick, load, start, pause;
  logic [15:0] load_value;
  logic [15:0] digits;
  logic        running, zero, done;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: value held as a plain integer
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;
  int m_val  = 0;
  int m_st   = M_IDLE;
  bit m_done = 1'b0;

  typedef struct {
    logic        r, t, l;
    logic [15:0] lv;
    logic        s, p;
    logic [15:0] e_dig;
    logic        e_run, e_done;
  } vec_t;
  vec_t tbl[17];

  bcd_countdown_timer #(.NUM_DIGITS(4), .DIGIT_MAX(9)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tick      (tick),
    .i_load      (load),
    .i_load_value(load_value),
    .i_start     (start),
    .i_pause     (pause),
    .o_digits    (digits),
    .o_running   (running),
    .o_zero      (zero),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int preset_val(input logic [15:0] lv);
    int v, w, d;
    v = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(lv[i*4 +: 4]);
      if (d > 9) d = 9;
      v = v + d * w;
      w = w * 10;
    end
    return v;
  endfunction

  task automatic model_update(input logic r, t, l, input logic [15:0] lv,
                              input logic s, p);
    m_done = 1'b0;
    if (r) begin
      m_val = 0;
      m_st  = M_IDLE;
    end else if (l) begin
      m_val = preset_val(lv);
      m_st  = M_IDLE;
    end else begin
      case (m_st)
        M_IDLE:
          if (s) begin
            if (m_val == 0) begin
              m_st   = M_EXP;
              m_done = 1'b1;
            end else m_st = M_RUN;
          end
        M_RUN:
          if (p) m_st = M_PAUSED;
          else if (t) begin
            m_val = m_val - 1;
            if (m_val == 0) begin
              m_st   = M_EXP;
              m_done = 1'b1;
            end
          end
        M_PAUSED:
          if (s && !p) m_st = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // drive one cycle, advance the model, compare all outputs 1 time unit after the edge
  task automatic step(input logic r, t, l, input logic [15:0] lv, input logic s, p);
    rst = r; tick = t; load = l; load_value = lv; start = s; pause = p;
    @(posedge clk);
    model_update(r, t, l, lv, s, p);
    #1;
    chk("digits",  digits,          to_bcd(m_val));
    chk("running", 16'(running),    16'(m_st == M_RUN));
    chk("zero",    16'(zero),       16'(m_val == 0));
    chk("done",    16'(done),       16'(m_done));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic tck();
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [15:0] v);
    step(1'b0, 1'b0, 1'b1, v, 1'b0, 1'b0);
  endtask

  task automatic go();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'hA5F3, 1'b0, 1'b0, 16'h9593, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h9593, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h9592, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h9592, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h9592, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9592, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h9592, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h9591, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1; tick = 1'b0; load = 1'b0; load_value = '0; start = 1'b0; pause = 1'b0;

    // vector table
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].t, tbl[i].l, tbl[i].lv, tbl[i].s, tbl[i].p);
      chk("tbl_digits",  digits,       tbl[i].e_dig);
      chk("tbl_running", 16'(running), 16'(tbl[i].e_run));
      chk("tbl_done",    16'(done),    16'(tbl[i].e_done));
      chk("tbl_zero",    16'(zero),    16'(tbl[i].e_dig == 16'h0));
    end

    // reset mid-count from 0057
    ld(16'h0057); go(); tck(); tck();
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    idle();
    chk("rst_digits", digits, 16'h0000);
    chk("rst_run",    16'(running), 16'h0);
    chk("rst_done",   16'(done), 16'h0);
    chk("rst_zero",   16'(zero), 16'h1);

    // 0012 counted down with ticks spaced three cycles apart
    ld(16'h0012); go();
    for (int k = 1; k <= 12; k++) begin
      tck();
      chk("cd_digits", digits, to_bcd(12 - k));
      chk("cd_done",   16'(done), 16'(k == 12));
      idle(); idle();
    end
    tck(); tck();
    chk("cd_hold", digits, 16'h0000);

    // multi-digit borrow wrap
    ld(16'h0100); go(); tck();
    chk("wrap2", digits, 16'h0099);
    ld(16'h1000); go(); tck();
    chk("wrap3", digits, 16'h0999);

    // pause with coincident tick, ticks while paused, resume
    ld(16'h0050); go();
    repeat (5) tck();
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("pause_hold", digits, 16'h0045);
    repeat (3) tck();
    chk("pause_ign", digits, 16'h0045);
    go(); tck();
    chk("resume", digits, 16'h0044);

    // load with coincident tick during RUN
    ld(16'h0017); go();
    step(1'b0, 1'b1, 1'b1, 16'h0030, 1'b0, 1'b0);
    chk("ldrun_digits", digits, 16'h0030);
    chk("ldrun_run",    16'(running), 16'h0);
    chk("ldrun_done",   16'(done), 16'h0);

    // random stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 3) != 0)
        v = to_bcd(int'($urandom_range(0, 40)));
      step(1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0),
           v,
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 11) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
